// File: rtl/io_pkg.sv
// Shared definitions for the I/O interrupt controller: byte width,
// output-side FSM states and io_error bit positions.
package io_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_BUSY = 1'b1
    } out_state_t;

    localparam int ERR_INP = 0;
    localparam int ERR_OUT = 1;

endpackage

// File: rtl/io_in_fifo.sv
// Show-ahead input FIFO. The head entry is presented on rd_data whenever the
// FIFO is non-empty and forced to 0 when empty. full/empty come from a
// registered occupancy counter one bit wider than the wrapping pointers.
module io_in_fifo #(
    parameter int IN_DEPTH = 4,
    parameter int DATA_W   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(IN_DEPTH):0]    occupancy,
    output logic                         full,
    output logic                         empty,
    output logic                         empty_next
);

    localparam int PTR_W = $clog2(IN_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(IN_DEPTH);

    logic [DATA_W-1:0] mem [IN_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;

    // Occupancy after this cycle's push/pop; callers guard push with !full
    // and pop with !empty.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and occupancy registers; contents are discarded on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage array; unread slots are masked by empty so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign occupancy  = count;
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign empty_next = (count_next == '0);
    assign rd_data    = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_interrupt_controller.sv
// Byte I/O sequencer beside an accumulator CPU: input FIFO feeding INPR/FGI,
// OUTR holding register with FGO, and the IEN/IRQ interrupt logic.
//
// Handshakes: a device transfer happens in exactly the cycle where both
// valid and ready are high at the rising clock edge; valid never depends on
// ready, and dev_out_data stays constant while dev_out_valid is high.
module io_interrupt_controller #(
    parameter int IN_DEPTH = 4,
    parameter int DATA_W   = io_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic              cpu_inp_rd,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    input  logic              cpu_out_wr,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              fgo,
    input  logic              cpu_ion,
    input  logic              cpu_iof,
    output logic              ien,
    output logic              irq,
    input  logic              irq_ack,
    output logic [1:0]        io_error
);

    import io_pkg::*;

    logic                       in_push;
    logic                       in_pop;
    logic                       in_full;
    logic                       in_empty;
    logic                       in_empty_next;
    logic [$clog2(IN_DEPTH):0]  in_count;

    out_state_t                 out_state;
    out_state_t                 out_state_next;
    logic [DATA_W-1:0]          outr;
    logic                       out_load;
    logic                       ien_next;
    logic                       ack_take;

    assign in_push = dev_in_valid & ~in_full;
    assign in_pop  = cpu_inp_rd & ~in_empty;

    io_in_fifo #(
        .IN_DEPTH (IN_DEPTH),
        .DATA_W   (DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (in_push),
        .wr_data    (dev_in_data),
        .pop        (in_pop),
        .rd_data    (inpr),
        .occupancy  (in_count),
        .full       (in_full),
        .empty      (in_empty),
        .empty_next (in_empty_next)
    );

    assign dev_in_ready = ~in_full;
    assign fgi          = ~in_empty;

    // Output FSM next state: OUT loads OUTR from idle, device accept frees it.
    always_comb begin
        out_state_next = out_state;
        out_load       = 1'b0;
        case (out_state)
            O_IDLE: begin
                if (cpu_out_wr) begin
                    out_load       = 1'b1;
                    out_state_next = O_BUSY;
                end
            end
            O_BUSY: begin
                if (dev_out_ready) out_state_next = O_IDLE;
            end
            default: out_state_next = O_IDLE;
        endcase
    end

    // Output FSM state and OUTR holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_state <= O_IDLE;
            outr      <= '0;
        end else begin
            out_state <= out_state_next;
            if (out_load) outr <= cpu_out_data;
        end
    end

    assign fgo           = (out_state == O_IDLE);
    assign dev_out_valid = (out_state == O_BUSY);
    assign dev_out_data  = outr;

    // IEN next state; an ack only counts while a request is outstanding.
    always_comb begin
        ack_take = irq_ack & irq;
        ien_next = ien;
        if (ack_take)     ien_next = 1'b0;
        else if (cpu_iof) ien_next = 1'b0;
        else if (cpu_ion) ien_next = 1'b1;
    end

    // Interrupt enable, registered request and sticky misuse flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ien      <= 1'b0;
            irq      <= 1'b0;
            io_error <= '0;
        end else begin
            ien <= ien_next;
            irq <= ien_next & (~in_empty_next | (out_state_next == O_IDLE));
            if (cpu_inp_rd & in_empty)         io_error[ERR_INP] <= 1'b1;
            if (cpu_out_wr & (out_state == O_BUSY)) io_error[ERR_OUT] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_interrupt_controller.sv
// Directed bench for io_interrupt_controller: FIFO ordering and full/empty
// boundaries, OUTR hold and misuse, interrupt enable/ack and async reset.
module tb_io_interrupt_controller;

    logic       clock;
    logic       reset;
    logic [7:0] dev_in_data;
    logic       dev_in_valid;
    logic       dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid;
    logic       dev_out_ready;
    logic       cpu_inp_rd;
    logic [7:0] inpr;
    logic       fgi;
    logic       cpu_out_wr;
    logic [7:0] cpu_out_data;
    logic       fgo;
    logic       cpu_ion;
    logic       cpu_iof;
    logic       ien;
    logic       irq;
    logic       irq_ack;
    logic [1:0] io_error;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    io_interrupt_controller #(.IN_DEPTH(4), .DATA_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .cpu_inp_rd    (cpu_inp_rd),
        .inpr          (inpr),
        .fgi           (fgi),
        .cpu_out_wr    (cpu_out_wr),
        .cpu_out_data  (cpu_out_data),
        .fgo           (fgo),
        .cpu_ion       (cpu_ion),
        .cpu_iof       (cpu_iof),
        .ien           (ien),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .io_error      (io_error)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance one rising edge; inputs change and outputs are sampled 1 unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        dev_in_data  = b;
        dev_in_valid = 1'b1;
        tick();
        dev_in_valid = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic read_byte(input string tag);
        exp_b = exp_q.pop_front();
        check(tag, 32'(inpr), 32'(exp_b));
        cpu_inp_rd = 1'b1;
        tick();
        cpu_inp_rd = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fgi"},   32'(fgi), 32'd0);
        check({tag, "_inpr"},  32'(inpr), 32'd0);
        check({tag, "_ready"}, 32'(dev_in_ready), 32'd1);
        check({tag, "_outd"},  32'(dev_out_data), 32'd0);
        check({tag, "_outv"},  32'(dev_out_valid), 32'd0);
        check({tag, "_fgo"},   32'(fgo), 32'd1);
        check({tag, "_ien"},   32'(ien), 32'd0);
        check({tag, "_irq"},   32'(irq), 32'd0);
        check({tag, "_err"},   32'(io_error), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        dev_in_data = '0; dev_in_valid = 1'b0; dev_out_ready = 1'b0;
        cpu_inp_rd = 1'b0; cpu_out_wr = 1'b0; cpu_out_data = '0;
        cpu_ion = 1'b0; cpu_iof = 1'b0; irq_ack = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b1;
        tick();

        // single byte round trip
        push_byte(8'd127);
        check("t1_fgi", 32'(fgi), 32'd1);
        read_byte("t1_inpr");
        check("t1_fgi_after", 32'(fgi), 32'd0);
        check("t1_inpr_after", 32'(inpr), 32'd0);

        // fill to full, fifth byte held off even across a pop
        push_byte(8'd127);
        push_byte(8'd25);
        push_byte(8'd240);
        check("t2_ready_3", 32'(dev_in_ready), 32'd1);
        push_byte(8'd10);
        check("t2_ready_full", 32'(dev_in_ready), 32'd0);
        dev_in_data  = 8'd55;
        dev_in_valid = 1'b1;
        tick();
        check("t2_hold_cnt", 32'(dut.in_count), 32'd4);
        exp_b = exp_q.pop_front();
        check("t2_rd0", 32'(inpr), 32'(exp_b));
        cpu_inp_rd = 1'b1;
        tick();
        cpu_inp_rd   = 1'b0;
        dev_in_valid = 1'b0;
        check("t2_nopass_cnt", 32'(dut.in_count), 32'd3);
        check("t2_ready_back", 32'(dev_in_ready), 32'd1);
        read_byte("t2_rd1");
        read_byte("t2_rd2");
        read_byte("t2_rd3");
        check("t2_empty", 32'(fgi), 32'd0);

        // simultaneous push and pop at two entries
        push_byte(8'd1);
        push_byte(8'd2);
        exp_b = exp_q.pop_front();
        check("t3_head", 32'(inpr), 32'(exp_b));
        dev_in_data  = 8'd7;
        dev_in_valid = 1'b1;
        cpu_inp_rd   = 1'b1;
        tick();
        dev_in_valid = 1'b0;
        cpu_inp_rd   = 1'b0;
        exp_q.push_back(8'd7);
        check("t3_cnt", 32'(dut.in_count), 32'd2);
        read_byte("t3_rd2");
        read_byte("t3_rd7");

        // INP while empty
        cpu_inp_rd = 1'b1;
        tick();
        cpu_inp_rd = 1'b0;
        check("t3_err0", 32'(io_error), 32'b01);
        check("t3_inpr0", 32'(inpr), 32'd0);

        // OUT held against a stalled device, second OUT rejected
        cpu_out_data = 8'h5A;
        cpu_out_wr   = 1'b1;
        tick();
        cpu_out_wr = 1'b0;
        check("t4_fgo", 32'(fgo), 32'd0);
        check("t4_valid", 32'(dev_out_valid), 32'd1);
        check("t4_data", 32'(dev_out_data), 32'h5A);
        tick();
        tick();
        check("t4_data_hold", 32'(dev_out_data), 32'h5A);
        cpu_out_data = 8'h11;
        cpu_out_wr   = 1'b1;
        tick();
        cpu_out_wr = 1'b0;
        check("t4_err1", 32'(io_error), 32'b11);
        check("t4_data_kept", 32'(dev_out_data), 32'h5A);
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        check("t4_fgo_free", 32'(fgo), 32'd1);
        check("t4_valid_lo", 32'(dev_out_valid), 32'd0);

        // interrupt enable and acknowledge
        cpu_ion = 1'b1;
        tick();
        cpu_ion = 1'b0;
        check("t5_ien", 32'(ien), 32'd1);
        check("t5_irq", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_ack_ien", 32'(ien), 32'd0);
        check("t5_ack_irq", 32'(irq), 32'd0);

        // enabled but no flag set: ack without a request is ignored
        cpu_out_data = 8'h22;
        cpu_out_wr   = 1'b1;
        tick();
        cpu_out_wr = 1'b0;
        cpu_ion    = 1'b1;
        tick();
        cpu_ion = 1'b0;
        check("t5_ien_noflag", 32'(ien), 32'd1);
        check("t5_irq_noflag", 32'(irq), 32'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_ack_ignored", 32'(ien), 32'd1);
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        check("t5_irq_on_fgo", 32'(irq), 32'd1);
        cpu_ion = 1'b1;
        cpu_iof = 1'b1;
        tick();
        cpu_ion = 1'b0;
        cpu_iof = 1'b0;
        check("t5_iof_wins", 32'(ien), 32'd0);
        check("t5_iof_irq", 32'(irq), 32'd0);

        // async reset with OUTR busy and FIFO holding a byte
        cpu_out_data = 8'h33;
        cpu_out_wr   = 1'b1;
        dev_in_data  = 8'd240;
        dev_in_valid = 1'b1;
        cpu_ion      = 1'b1;
        tick();
        cpu_out_wr   = 1'b0;
        dev_in_valid = 1'b0;
        cpu_ion      = 1'b0;
        check("t6_busy", 32'(dev_out_valid), 32'd1);
        check("t6_inpr", 32'(inpr), 32'd240);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("t6_async");
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("t6_fgo", 32'(fgo), 32'd1);
        check("t6_fgi", 32'(fgi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // bound the run in case a step never returns
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_interrupt_controller.md
Name: io_interrupt_controller

Overview:
- Sequences byte I/O between external devices and the CPU's accumulator-based INP/OUT instructions; sits beside the CPU, driving INPR/FGI/FGO/IEN and the interrupt request.
- Input side: small show-ahead FIFO fed by a valid/ready device port.
- Output side: single OUTR holding register drained by a valid/ready device port.
- Interrupt logic raises a request when enabled and either flag is set.

Parameters:
- IN_DEPTH, 4, input FIFO depth in bytes; power of 2, minimum 2.
- DATA_W, 8, I/O byte width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dev_in_data  in  DATA_W  input device byte.
- dev_in_valid  in  1  input device offers byte.
- dev_in_ready  out  1  FIFO can accept.
- dev_out_data  out  DATA_W  OUTR contents.
- dev_out_valid  out  1  OUTR holds an undelivered byte.
- dev_out_ready  in  1  output device accepts.
- cpu_inp_rd  in  1  INP instruction strobe; pops FIFO head.
- inpr  out  DATA_W  FIFO head byte (show-ahead), 0 when empty.
- fgi  out  1  input flag = FIFO non-empty.
- cpu_out_wr  in  1  OUT instruction strobe.
- cpu_out_data  in  DATA_W  AC[7:0] for OUT.
- fgo  out  1  output flag, 1 = OUTR free.
- cpu_ion  in  1  ION strobe, sets IEN.
- cpu_iof  in  1  IOF strobe, clears IEN.
- ien  out  1  interrupt enable.
- irq  out  1  interrupt request to CPU.
- irq_ack  in  1  CPU entered interrupt cycle.
- io_error  out  2  sticky bits: [0] INP with fgi=0, [1] OUT with fgo=0.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; fgi=0, inpr=0, dev_in_ready=1.
  - OUTR=0, dev_out_valid=0, fgo=1.
  - ien=0, irq=0, io_error=0.
- Input FIFO:
  - Push on dev_in_valid & dev_in_ready.
  - dev_in_ready = !full, registered from occupancy; no pass-through when full, even if a pop happens that cycle.
  - Pop on cpu_inp_rd & fgi. inpr updates to the next entry the cycle after the pop.
  - Push and pop in the same cycle: occupancy unchanged, both succeed (when not full).
  - Pointers are log2(IN_DEPTH) bits and wrap; an occupancy counter one bit wider gives full/empty.
  - cpu_inp_rd while empty: no pop, inpr stays 0, io_error[0] set.
- Output FSM:
  - States O_IDLE (fgo=1, dev_out_valid=0) and O_BUSY (fgo=0, dev_out_valid=1).
  - O_IDLE: cpu_out_wr loads OUTR, moves to O_BUSY next cycle.
  - O_BUSY: dev_out_ready moves to O_IDLE next cycle. OUTR holds its value; dev_out_data is stable while valid.
  - cpu_out_wr in O_BUSY: ignored, OUTR unchanged, io_error[1] set.
  - Minimum OUT-to-OUT spacing is 2 cycles.
- Interrupt:
  - ien next-state priority: irq_ack (clear) > cpu_iof (clear) > cpu_ion (set) > hold.
  - irq registered: irq <= ien_next & (fgi_next | fgo_next), so irq drops the cycle after any ack or IOF.
  - irq_ack while irq=0: ignored, no state change.
  - Flags are not cleared by ack; the CPU service routine clears them via INP/OUT.
- io_error bits are sticky and clear only on reset.
- Reset asserted mid-transfer: OUTR byte discarded, FIFO contents discarded.
- No combinational path from any input to any output except inpr/fgi, which come from FIFO registers only.

Decomposition:
- Shared package (io_pkg): DATA_W, output FSM state enum {O_IDLE, O_BUSY}, io_error bit index constants.
- One sub-module: io_in_fifo (parameterised IN_DEPTH/DATA_W, show-ahead, occupancy/full/empty outputs).
- The output FSM and interrupt logic stay in the top module.

Test Plan:
- Reset then push 127 -> fgi=1 and inpr=127 one cycle after acceptance. cpu_inp_rd -> fgi=0, inpr=0 next cycle.
- Push 127, 25, 240, 10 with no reads -> dev_in_ready=0 after the 4th byte. A 5th byte (55) is held off. Reads return 127, 25, 240, 10 in order, and ready reasserts after the first pop.
- FIFO at 2 entries, push 7 and cpu_inp_rd in the same cycle -> occupancy stays 2, head advances, 7 is read later.
- cpu_out_wr with data 0x5A while dev_out_ready=0 for 3 cycles -> fgo=0, dev_out_valid=1, dev_out_data=0x5A held. A second OUT of 0x11 sets io_error[1], OUTR stays 0x5A. dev_out_ready=1 -> fgo=1 next cycle.
- cpu_ion with fgo=1 -> ien=1, irq=1 next cycle. irq_ack -> ien=0, irq=0 next cycle. cpu_ion and cpu_iof in the same cycle -> ien=0.
- Assert reset with OUTR busy and FIFO holding 240 -> all outputs at reset values immediately (asynchronous). After release, fgo=1 and fgi=0.
